// File: rtl/cdb_arbiter_pkg.sv
// Shared types for the common data bus arbiter: FU result records, the CDB
// broadcast record and ROB age helpers.
package cdb_arbiter_pkg;

  localparam int PREG_W   = 7;
  localparam int ROB_W    = 5;
  localparam int XLEN     = 32;
  localparam int CDB_NSRC = 3;

  typedef enum logic [1:0] {
    SRC_ALU = 2'd0,
    SRC_MEM = 2'd1,
    SRC_B   = 2'd2
  } cdb_src_e;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] pd;
    logic [ROB_W-1:0]  rob_tag;
    logic [XLEN-1:0]   data;
    logic [1:0]        src;
    logic              mispredict;
    logic              jalr_bne;
    logic [XLEN-1:0]   pc;
  } cdb_data;

  typedef struct packed {
    logic              done;
    logic [PREG_W-1:0] p_alu;
    logic [ROB_W-1:0]  rob;
    logic [XLEN-1:0]   data;
  } alu_data;

  typedef struct packed {
    logic              done;
    logic [PREG_W-1:0] p_mem;
    logic [ROB_W-1:0]  rob;
    logic [XLEN-1:0]   data;
  } mem_data;

  typedef struct packed {
    logic              done;
    logic [PREG_W-1:0] p_b;
    logic [ROB_W-1:0]  rob;
    logic [XLEN-1:0]   data;
    logic              mispredict;
    logic              jalr_bne;
    logic [XLEN-1:0]   pc;
  } b_data;

  // Distance from the ROB head; modulo arithmetic handles tag wrap-around.
  function automatic logic [ROB_W-1:0] rob_age(input logic [ROB_W-1:0] tag,
                                               input logic [ROB_W-1:0] head);
    return tag - head;
  endfunction

  function automatic logic is_younger(input logic [ROB_W-1:0] tag,
                                      input logic [ROB_W-1:0] ref_tag,
                                      input logic [ROB_W-1:0] head);
    return rob_age(tag, head) > rob_age(ref_tag, head);
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_arb3.sv
// Combinational 3-way round-robin picker: grants the first requester at or
// after rr_ptr, wrapping modulo 3.
module rr_arb3 (
  input  logic [2:0] req,
  input  logic [1:0] rr_ptr,
  output logic [2:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       any
);

  // An out-of-range pointer (3) behaves like 0.
  always_comb begin
    gnt_idx = 2'd0;
    case (rr_ptr)
      2'd1: begin
        if (req[1])      gnt_idx = 2'd1;
        else if (req[2]) gnt_idx = 2'd2;
        else             gnt_idx = 2'd0;
      end
      2'd2: begin
        if (req[2])      gnt_idx = 2'd2;
        else if (req[0]) gnt_idx = 2'd0;
        else             gnt_idx = 2'd1;
      end
      default: begin
        if (req[0])      gnt_idx = 2'd0;
        else if (req[1]) gnt_idx = 2'd1;
        else             gnt_idx = 2'd2;
      end
    endcase
    any = |req;
    gnt = any ? (3'b001 << gnt_idx) : 3'b000;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Shares the CDB between ALU, MEM and branch FUs: one pending slot per FU,
// round-robin grant, flush filtering of younger results, registered broadcast.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  alu_data          alu_in,
  input  mem_data          mem_in,
  input  b_data            b_in,
  output logic             alu_ready,
  output logic             mem_ready,
  output logic             b_ready,
  input  logic [ROB_W-1:0] rob_head,
  input  logic             flush,
  input  logic [ROB_W-1:0] flush_tag,
  output cdb_data          cdb_out
);

  cdb_data               slot [CDB_NSRC];
  logic [CDB_NSRC-1:0]   slot_valid;
  logic [1:0]            rr_ptr;

  cdb_data               inc  [CDB_NSRC];
  cdb_data               cand [CDB_NSRC];
  logic [CDB_NSRC-1:0]   inc_done;
  logic [CDB_NSRC-1:0]   inc_ok;
  logic [CDB_NSRC-1:0]   slot_live;
  logic [CDB_NSRC-1:0]   req;
  logic [CDB_NSRC-1:0]   gnt;
  logic [1:0]            gnt_idx;
  logic                  any;

  // Normalise each FU result into the broadcast record; branch-only fields
  // stay zero for ALU and MEM.
  always_comb begin
    inc[0]         = '0;
    inc[0].valid   = 1'b1;
    inc[0].pd      = alu_in.p_alu;
    inc[0].rob_tag = alu_in.rob;
    inc[0].data    = alu_in.data;
    inc[0].src     = SRC_ALU;

    inc[1]         = '0;
    inc[1].valid   = 1'b1;
    inc[1].pd      = mem_in.p_mem;
    inc[1].rob_tag = mem_in.rob;
    inc[1].data    = mem_in.data;
    inc[1].src     = SRC_MEM;

    inc[2]            = '0;
    inc[2].valid      = 1'b1;
    inc[2].pd         = b_in.p_b;
    inc[2].rob_tag    = b_in.rob;
    inc[2].data       = b_in.data;
    inc[2].src        = SRC_B;
    inc[2].mispredict = b_in.mispredict;
    inc[2].jalr_bne   = b_in.jalr_bne;
    inc[2].pc         = b_in.pc;

    inc_done = {b_in.done, mem_in.done, alu_in.done};
  end

  // A done while the slot is occupied is ignored; the slot keeps priority.
  always_comb begin
    for (int i = 0; i < CDB_NSRC; i++) begin
      slot_live[i] = slot_valid[i] &
                     ~(flush & is_younger(slot[i].rob_tag, flush_tag, rob_head));
      inc_ok[i]    = inc_done[i] & ~slot_valid[i] &
                     ~(flush & is_younger(inc[i].rob_tag, flush_tag, rob_head));
      req[i]       = slot_live[i] | inc_ok[i];
      cand[i]      = slot_valid[i] ? slot[i] : inc[i];
    end
  end

  rr_arb3 u_rr_arb3 (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Winners leave (or bypass) their slot; losing survivors are parked.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      slot_valid <= '0;
      rr_ptr     <= 2'd0;
      cdb_out    <= '0;
      for (int i = 0; i < CDB_NSRC; i++) begin
        slot[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CDB_NSRC; i++) begin
        if (gnt[i]) begin
          slot_valid[i] <= 1'b0;
        end else if (inc_ok[i]) begin
          slot_valid[i] <= 1'b1;
          slot[i]       <= inc[i];
        end else begin
          slot_valid[i] <= slot_live[i];
        end
      end
      if (any) begin
        cdb_out       <= cand[gnt_idx];
        cdb_out.valid <= 1'b1;
        rr_ptr        <= (gnt_idx == 2'd2) ? 2'd0 : gnt_idx + 2'd1;
      end else begin
        cdb_out <= '0;
      end
    end
  end

  assign alu_ready = reset_n & ~slot_valid[0];
  assign mem_ready = reset_n & ~slot_valid[1];
  assign b_ready   = reset_n & ~slot_valid[2];

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: single results, contention, fairness,
// flush filtering with ROB wrap-around and mid-operation reset.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             reset_n;
  alu_data          alu_in;
  mem_data          mem_in;
  b_data            b_in;
  logic             alu_ready, mem_ready, b_ready;
  logic [ROB_W-1:0] rob_head;
  logic             flush;
  logic [ROB_W-1:0] flush_tag;
  cdb_data          cdb_out;

  int num_checks;
  int num_pass;
  logic [2:0] exp_fair;

  always #5 clk = ~clk;

  cdb_arbiter dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .alu_in    (alu_in),
    .mem_in    (mem_in),
    .b_in      (b_in),
    .alu_ready (alu_ready),
    .mem_ready (mem_ready),
    .b_ready   (b_ready),
    .rob_head  (rob_head),
    .flush     (flush),
    .flush_tag (flush_tag),
    .cdb_out   (cdb_out)
  );

  // Presenting a result while not ready is a protocol violation.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(alu_in.done && !alu_ready)) else $error("[TB] protocol: alu done while not ready");
      assert (!(mem_in.done && !mem_ready)) else $error("[TB] protocol: mem done while not ready");
      assert (!(b_in.done && !b_ready))     else $error("[TB] protocol: b done while not ready");
    end
  end

  task automatic check_output(input string tag, input logic [127:0] got, input logic [127:0] exp);
    num_checks++;
    if (got !== exp) $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    else num_pass++;
  endtask

  function automatic cdb_data mk_cdb(input logic [6:0] pd, input logic [4:0] tag,
                                     input logic [31:0] data, input logic [1:0] src,
                                     input logic mp, input logic jb, input logic [31:0] pc);
    cdb_data c;
    c = '0;
    c.valid = 1'b1; c.pd = pd; c.rob_tag = tag; c.data = data;
    c.src = src; c.mispredict = mp; c.jalr_bne = jb; c.pc = pc;
    return c;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_idle();
    alu_in = '0;
    mem_in = '0;
    b_in   = '0;
  endtask

  task automatic drive_alu(input logic [6:0] pd, input logic [4:0] tag, input logic [31:0] data);
    alu_in = '{done: 1'b1, p_alu: pd, rob: tag, data: data};
  endtask

  task automatic drive_mem(input logic [6:0] pd, input logic [4:0] tag, input logic [31:0] data);
    mem_in = '{done: 1'b1, p_mem: pd, rob: tag, data: data};
  endtask

  task automatic drive_b(input logic [6:0] pd, input logic [4:0] tag, input logic [31:0] data,
                         input logic mp, input logic jb, input logic [31:0] pc);
    b_in = '{done: 1'b1, p_b: pd, rob: tag, data: data, mispredict: mp, jalr_bne: jb, pc: pc};
  endtask

  function automatic logic [2:0] readies();
    return {alu_ready, mem_ready, b_ready};
  endfunction

  initial begin
    num_checks = 0;
    num_pass   = 0;
    reset_n    = 1'b0;
    flush      = 1'b0;
    flush_tag  = '0;
    rob_head   = '0;
    apply_idle();
    next_cycle();
    next_cycle();
    check_output("ready_in_reset", 128'(readies()), 128'(3'b000));
    check_output("cdb_reset", 128'(cdb_out), 128'(0));
    reset_n = 1'b1;
    #1;
    check_output("ready_after_reset", 128'(readies()), 128'(3'b111));

    // Single ALU result
    drive_alu(7'h12, 5'd3, 32'hDEADBEEF);
    next_cycle();
    apply_idle();
    check_output("alu_single", 128'(cdb_out), 128'(mk_cdb(7'h12, 5'd3, 32'hDEADBEEF, SRC_ALU, 1'b0, 1'b0, 32'h0)));
    check_output("alu_single_ready", 128'(alu_ready), 128'(1'b1));
    check_output("rr_after_alu", 128'(dut.rr_ptr), 128'(2'd1));

    // Single branch with pd=0 is still broadcast
    drive_b(7'h00, 5'd7, 32'h55, 1'b0, 1'b0, 32'h100);
    next_cycle();
    apply_idle();
    check_output("b_pd0", 128'(cdb_out), 128'(mk_cdb(7'h00, 5'd7, 32'h55, SRC_B, 1'b0, 1'b0, 32'h100)));
    check_output("rr_after_b", 128'(dut.rr_ptr), 128'(2'd0));
    next_cycle();
    check_output("idle_valid", 128'(cdb_out.valid), 128'(1'b0));

    // Three-way contention from rr_ptr=0
    drive_alu(7'h01, 5'd10, 32'hA);
    drive_mem(7'h02, 5'd11, 32'hB);
    drive_b(7'h03, 5'd12, 32'hC, 1'b0, 1'b1, 32'h200);
    next_cycle();
    apply_idle();
    check_output("c3_alu", 128'(cdb_out), 128'(mk_cdb(7'h01, 5'd10, 32'hA, SRC_ALU, 1'b0, 1'b0, 32'h0)));
    check_output("c3_ready1", 128'(readies()), 128'(3'b100));
    next_cycle();
    check_output("c3_mem", 128'(cdb_out), 128'(mk_cdb(7'h02, 5'd11, 32'hB, SRC_MEM, 1'b0, 1'b0, 32'h0)));
    check_output("c3_ready2", 128'(readies()), 128'(3'b110));
    next_cycle();
    check_output("c3_b", 128'(cdb_out), 128'(mk_cdb(7'h03, 5'd12, 32'hC, SRC_B, 1'b0, 1'b1, 32'h200)));
    check_output("c3_ready3", 128'(readies()), 128'(3'b111));
    check_output("c3_rr", 128'(dut.rr_ptr), 128'(2'd0));
    next_cycle();
    check_output("c3_idle", 128'(cdb_out.valid), 128'(1'b0));

    // Fairness: ALU and MEM present whenever ready; grants alternate ALU, MEM, ...
    for (int k = 0; k < 8; k++) begin
      if (k > 0) begin
        exp_fair = (k % 2 == 1) ? {1'b1, SRC_ALU} : {1'b1, SRC_MEM};
        check_output("fair_src", 128'({cdb_out.valid, cdb_out.src}), 128'(exp_fair));
      end
      apply_idle();
      if (alu_ready) drive_alu(7'h05, 5'(k), 32'(k));
      if (mem_ready) drive_mem(7'h06, 5'(k + 16), 32'(k + 100));
      next_cycle();
    end
    apply_idle();
    check_output("fair_src_last", 128'({cdb_out.valid, cdb_out.src}), 128'({1'b1, SRC_MEM}));
    next_cycle();
    check_output("fair_drain", 128'({cdb_out.valid, cdb_out.src}), 128'({1'b1, SRC_ALU}));
    next_cycle();
    check_output("fair_empty", 128'({cdb_out.valid, readies()}), 128'(4'b0111));

    // Realign rr_ptr to 0 with a lone branch result
    drive_b(7'h09, 5'd1, 32'h77, 1'b0, 1'b0, 32'h180);
    next_cycle();
    apply_idle();
    check_output("realign_b", 128'(cdb_out), 128'(mk_cdb(7'h09, 5'd1, 32'h77, SRC_B, 1'b0, 1'b0, 32'h180)));

    // Flush with ROB wrap-around: head=30, MEM tag 4 is younger than flush tag 2
    rob_head = 5'd30;
    drive_alu(7'h20, 5'd30, 32'h30);
    drive_mem(7'h21, 5'd4, 32'h40);
    drive_b(7'h22, 5'd2, 32'h50, 1'b1, 1'b0, 32'h300);
    next_cycle();
    apply_idle();
    check_output("fl_pre_alu", 128'(cdb_out), 128'(mk_cdb(7'h20, 5'd30, 32'h30, SRC_ALU, 1'b0, 1'b0, 32'h0)));
    check_output("fl_pre_ready", 128'(readies()), 128'(3'b100));
    drive_alu(7'h23, 5'd31, 32'h31);
    flush     = 1'b1;
    flush_tag = 5'd2;
    next_cycle();
    apply_idle();
    flush = 1'b0;
    check_output("fl_b", 128'(cdb_out), 128'(mk_cdb(7'h22, 5'd2, 32'h50, SRC_B, 1'b1, 1'b0, 32'h300)));
    check_output("fl_ready", 128'(readies()), 128'(3'b011));
    next_cycle();
    check_output("fl_alu", 128'(cdb_out), 128'(mk_cdb(7'h23, 5'd31, 32'h31, SRC_ALU, 1'b0, 1'b0, 32'h0)));
    check_output("fl_ready2", 128'(readies()), 128'(3'b111));
    next_cycle();
    check_output("fl_mem_dropped", 128'(cdb_out.valid), 128'(1'b0));

    // Younger incoming result dropped in the flush cycle; the flushing branch survives
    rob_head  = 5'd0;
    flush     = 1'b1;
    flush_tag = 5'd5;
    drive_alu(7'h30, 5'd9, 32'h99);
    drive_b(7'h31, 5'd5, 32'h55, 1'b1, 1'b1, 32'h400);
    next_cycle();
    apply_idle();
    flush = 1'b0;
    check_output("fy_b", 128'(cdb_out), 128'(mk_cdb(7'h31, 5'd5, 32'h55, SRC_B, 1'b1, 1'b1, 32'h400)));
    check_output("fy_ready", 128'(readies()), 128'(3'b111));
    next_cycle();
    check_output("fy_no_alu", 128'(cdb_out.valid), 128'(1'b0));

    // Reset mid-operation
    drive_alu(7'h40, 5'd1, 32'h1);
    drive_mem(7'h41, 5'd2, 32'h2);
    drive_b(7'h42, 5'd3, 32'h3, 1'b0, 1'b0, 32'h500);
    next_cycle();
    apply_idle();
    check_output("rs_busy", 128'({cdb_out.valid, readies()}), 128'(4'b1100));
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    #1;
    check_output("rs_cdb", 128'(cdb_out), 128'(0));
    check_output("rs_ready", 128'(readies()), 128'(3'b111));
    check_output("rs_rr", 128'(dut.rr_ptr), 128'(2'd0));
    drive_mem(7'h44, 5'd6, 32'h66);
    next_cycle();
    apply_idle();
    check_output("rs_mem", 128'(cdb_out), 128'(mk_cdb(7'h44, 5'd6, 32'h66, SRC_MEM, 1'b0, 1'b0, 32'h0)));
    check_output("rs_rr_mem", 128'(dut.rr_ptr), 128'(2'd2));

    $display("%0d/%0d checks passed", num_pass, num_checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between the three functional units: ALU, MEM and branch.
- Sits between the FU outputs and the writeback consumers: ROB complete-marking, RS wakeup and PRF write.
- Holds one pending result per FU, picks one result per cycle round-robin, and drives a registered CDB broadcast.
- On a mispredict flush, drops any pending result whose ROB tag is younger than the flush tag.

Parameters:
- PREG_W, 7, physical register index width
- ROB_W, 5, ROB tag width (32-entry ROB)
- XLEN, 32, data and PC width

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- alu_in  in  alu_data  ALU result; valid when fu_alu_done
- mem_in  in  mem_data  MEM result; valid when fu_mem_done
- b_in  in  b_data  branch result; valid when fu_b_done
- alu_ready  out  1  ALU may present a result this cycle
- mem_ready  out  1  MEM may present a result this cycle
- b_ready  out  1  branch FU may present a result this cycle
- rob_head  in  ROB_W  current ROB head tag, used for age compares
- flush  in  1  mispredict recovery this cycle
- flush_tag  in  ROB_W  ROB tag of the mispredicting branch
- cdb_out  out  cdb_data  registered CDB broadcast

Behaviour:
- Clock and reset: one clock, clk. reset_n is synchronous and active-low.
- Reset values: all slots empty; rr_ptr=0; cdb_out all zeros (valid=0).
- Ready outputs: *_ready = reset_n & ~slot_valid[i]. They come from registers only, so there is no combinational path from *_done.
- FU handshake: a result is accepted when done & ready. done asserted while ready=0 is a protocol violation; the bench asserts on it.
- Candidates: source order ALU=0, MEM=1, B=2. candidate[i] = slot[i] when slot_valid[i], else the incoming result when its done is high.
- Grant: the first valid candidate starting at rr_ptr, wrapping modulo 3.
- Pointer update: after granting source i, rr_ptr <= (i+1) mod 3. rr_ptr is unchanged when nothing is granted.
- Latency: 1 cycle. A result accepted in cycle N with no contention appears as cdb_out.valid=1 in cycle N+1. A bypassed result never occupies its slot.
- Losing candidates: an incoming result that loses arbitration is written into its slot. An occupied slot that wins is cleared at the edge.
- CDB register: cdb_out <= the granted candidate with valid=1, or all zeros if nothing is granted. It is held for exactly one cycle.
- Per-source fields:
  - mispredict, jalr_bne and pc are copied from b_in only when src=B; otherwise they are 0.
  - data comes from the source's data field.
  - pd comes from p_alu, p_mem or p_b.
- Age compare: age(t) = (t - rob_head) mod 2^ROB_W, computed as ROB_W-bit unsigned subtraction. t is younger than flush_tag iff age(t) > age(flush_tag).
- Flush cycle:
  - Every slot holding a younger tag is cleared.
  - Every incoming result with a younger tag is ignored; it is neither granted nor stored.
  - Arbitration proceeds over the survivors only.
  - The branch with tag == flush_tag itself is not killed.
  - A cdb_out already driven in the flush cycle is not retracted.
- Simultaneous events: flush together with reset_n=0 resolves to reset. A slot cleared by flush makes its ready high the following cycle.
- Destination p0: results with pd=0 (stores, branches without rd) are still broadcast. Consumers ignore pd=0 for register writes.

Decomposition:
- types_pkg additions:
  - typedef cdb_data: valid, pd[6:0], rob_tag[4:0], data[31:0], src[1:0], mispredict, jalr_bne, pc[31:0].
  - enum cdb_src_e: SRC_ALU=0, SRC_MEM=1, SRC_B=2.
  - Constant CDB_NSRC=3.
- Sub-module rr_arb3:
  - Pure combinational 3-way round-robin picker.
  - Inputs: req[2:0], rr_ptr[1:0]. Outputs: gnt one-hot, gnt_idx, any.
  - Reused later for issue-port arbitration.
- The top level holds the slots, the flush filter, rr_ptr and the CDB register.

Test Plan:
- Single ALU result: alu_in{p_alu=0x12, rob=3, data=0xDEADBEEF, done=1} in cycle N -> cycle N+1 cdb_out{valid=1, pd=0x12, rob_tag=3, data=0xDEADBEEF, src=0, mispredict=0}; alu_ready stays 1 throughout.
- Three-way contention: all three done in cycle N with rr_ptr=0 -> CDB shows ALU, MEM, B in cycles N+1, N+2, N+3. mem_ready=0 in N+1 and 1 in N+2. b_ready=0 in N+1..N+2 and 1 in N+3. rr_ptr ends at 0.
- Fairness: ALU and MEM each present a result whenever ready, for 8 cycles -> CDB alternates between the two sources; neither source is granted twice in a row while the other is pending.
- Flush with wrap-around: rob_head=30; slots hold ALU tag 31, MEM tag 4, B tag 2 with mispredict=1; flush=1, flush_tag=2 -> MEM killed (age 6 > 4); ALU (age 1) and B (age 4) survive; mem_ready=1 next cycle; B broadcast carries mispredict=1 and its pc.
- Incoming younger during flush: rob_head=0, flush_tag=5, alu_in tag 9 done in the flush cycle -> no CDB output for it, slot stays empty; tag 5 on b_in in the same cycle is broadcast.
- Reset mid-operation: all slots full and cdb valid; reset_n=0 for one cycle -> next cycle cdb_out.valid=0, all readies 1, rr_ptr=0. A subsequent single MEM result appears 1 cycle after acceptance.
